// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator: feedback form selectors and lock-state helper.
package lfsr_pkg;

    localparam int MODE_FIB = 0;
    localparam int MODE_GAL = 1;

    // All-ones is the stuck state for XNOR feedback, all-zeros for XOR feedback.
    function automatic logic [31:0] lock_val(input int width, input logic xnor_fb);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) begin
            v[i] = xnor_fb && (i < width);
        end
        return v;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state of the LFSR for either Fibonacci or Galois form.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH   = 5,
    parameter int               MODE    = MODE_FIB,
    parameter logic [WIDTH-1:0] TAPS    = 5'b10100,
    parameter bit               XNOR_FB = 1'b0
) (
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] nxt_o
);

    generate
        if (MODE == MODE_GAL) begin : g_galois
            assign nxt_o = {q_i[WIDTH-2:0], 1'b0} ^ ({WIDTH{q_i[WIDTH-1]}} & TAPS);
        end else begin : g_fib
            logic fb;
            assign fb    = (^(q_i & TAPS)) ^ XNOR_FB;
            assign nxt_o = {q_i[WIDTH-2:0], fb};
        end
    endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with runtime seed load, lock-up recovery and period (wrap) tracking.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH   = 5,
    parameter int               MODE    = MODE_FIB,
    parameter logic [WIDTH-1:0] TAPS    = 5'b10100,
    parameter bit               XNOR_FB = 1'b0,
    parameter logic [WIDTH-1:0] SEED    = 5'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             lockup,
    output logic             rec,
    output logic             wrap,
    output logic [WIDTH-1:0] cnt
);

    // XNOR only makes sense for the external-XOR form.
    localparam bit               XNOR_EFF  = (MODE == MODE_FIB) && XNOR_FB;
    localparam logic [31:0]      LOCK_FULL = lock_val(WIDTH, XNOR_EFF);
    localparam logic [WIDTH-1:0] LOCK      = LOCK_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             lockup_q, lockup_d;
    logic             rec_q, rec_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] nxt;

    lfsr_next #(
        .WIDTH  (WIDTH),
        .MODE   (MODE),
        .TAPS   (TAPS),
        .XNOR_FB(XNOR_EFF)
    ) u_next (
        .q_i  (q_q),
        .nxt_o(nxt)
    );

    always_comb begin
        q_d    = q_q;
        seed_d = seed_q;
        cnt_d  = cnt_q;
        rec_d  = 1'b0;
        wrap_d = 1'b0;
        if (load) begin
            q_d    = seed_in;
            seed_d = seed_in;
            cnt_d  = '0;
        end else if (en) begin
            if (q_q == LOCK) begin
                // A stored seed equal to LOCK would re-lock, so fall back to SEED.
                q_d   = (seed_q == LOCK) ? SEED : seed_q;
                cnt_d = '0;
                rec_d = 1'b1;
            end else begin
                q_d = nxt;
                if (nxt == seed_q) begin
                    wrap_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
        lockup_d = (q_d == LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q      <= SEED;
            seed_q   <= SEED;
            cnt_q    <= '0;
            lockup_q <= 1'b0;
            rec_q    <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            q_q      <= q_d;
            seed_q   <= seed_d;
            cnt_q    <= cnt_d;
            lockup_q <= lockup_d;
            rec_q    <= rec_d;
            wrap_q   <= wrap_d;
        end
    end

    assign q       = q_q;
    assign bit_out = q_q[WIDTH-1];
    assign lockup  = lockup_q;
    assign rec     = rec_q;
    assign wrap    = wrap_q;
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench: 5-bit Fibonacci XOR, 8-bit Galois and 5-bit Fibonacci XNOR instances.
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // 5-bit Fibonacci XOR, taps 10100, seed 01
    logic       f_rst, f_en, f_ld, f_bit, f_lk, f_rec, f_wrap;
    logic [4:0] f_seed, f_q, f_cnt;
    // 8-bit Galois, poly 0x11D, seed 01
    logic       g_rst, g_en, g_ld, g_bit, g_lk, g_rec, g_wrap;
    logic [7:0] g_seed, g_q, g_cnt;
    // 5-bit Fibonacci XNOR, seed 01
    logic       x_rst, x_en, x_ld, x_bit, x_lk, x_rec, x_wrap;
    logic [4:0] x_seed, x_q, x_cnt;

    lfsr_gen #(.WIDTH(5), .MODE(0), .TAPS(5'b10100), .XNOR_FB(1'b0), .SEED(5'h01)) u_fib (
        .clk(clk), .rst(f_rst), .en(f_en), .load(f_ld), .seed_in(f_seed),
        .q(f_q), .bit_out(f_bit), .lockup(f_lk), .rec(f_rec), .wrap(f_wrap), .cnt(f_cnt));

    lfsr_gen #(.WIDTH(8), .MODE(1), .TAPS(8'h1D), .XNOR_FB(1'b0), .SEED(8'h01)) u_gal (
        .clk(clk), .rst(g_rst), .en(g_en), .load(g_ld), .seed_in(g_seed),
        .q(g_q), .bit_out(g_bit), .lockup(g_lk), .rec(g_rec), .wrap(g_wrap), .cnt(g_cnt));

    lfsr_gen #(.WIDTH(5), .MODE(0), .TAPS(5'b10100), .XNOR_FB(1'b1), .SEED(5'h01)) u_xnr (
        .clk(clk), .rst(x_rst), .en(x_en), .load(x_ld), .seed_in(x_seed),
        .q(x_q), .bit_out(x_bit), .lockup(x_lk), .rec(x_rec), .wrap(x_wrap), .cnt(x_cnt));

    typedef struct {
        logic       rst;
        logic       ld;
        logic       en;
        logic [4:0] seed;
        logic [4:0] q;
        logic [4:0] cnt;
        logic       wrap;
        logic       rec;
        logic       lk;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           rst   ld    en    seed   q      cnt    wrap  rec   lk
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h02, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h04, 5'd2, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h09, 5'd3, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 5'h00, 5'h09, 5'd3, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h12, 5'd4, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h05, 5'd5, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 5'h0A, 5'h0A, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h14, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h08, 5'd2, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 5'h00, 5'h00, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h01, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h02, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 5'h00, 5'h00, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 5'h0A, 5'h01, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 5'h00, 5'h00, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h01, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 5'h0A, 5'h01, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h02, 5'd1, 1'b0, 1'b0, 1'b0};

        f_rst = 1'b1; f_en = 1'b0; f_ld = 1'b0; f_seed = '0;
        g_rst = 1'b1; g_en = 1'b0; g_ld = 1'b0; g_seed = '0;
        x_rst = 1'b1; x_en = 1'b0; x_ld = 1'b0; x_seed = '0;
        tick();
        tick();
        f_rst = 1'b0; g_rst = 1'b0; x_rst = 1'b0;

        chk("rst_fib_q", 32'(f_q), 32'h01);
        chk("rst_fib_cnt", 32'(f_cnt), 32'h0);
        chk("rst_fib_flags", {29'd0, f_lk, f_rec, f_wrap}, 32'h0);
        chk("rst_gal_q", 32'(g_q), 32'h01);
        chk("rst_xnr_q", 32'(x_q), 32'h01);
        chk("rst_xnr_flags", {29'd0, x_lk, x_rec, x_wrap}, 32'h0);

        // Fibonacci XOR: table of steps, holds, load/en collision, lock-up and reset overrides
        for (int i = 0; i < 19; i++) begin
            f_rst = vecs[i].rst; f_ld = vecs[i].ld; f_en = vecs[i].en; f_seed = vecs[i].seed;
            tick();
            chk($sformatf("vec%0d_q", i), 32'(f_q), 32'(vecs[i].q));
            chk($sformatf("vec%0d_bit", i), 32'(f_bit), 32'(vecs[i].q[4]));
            chk($sformatf("vec%0d_cnt", i), 32'(f_cnt), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_flags", i), {29'd0, f_lk, f_rec, f_wrap},
                {29'd0, vecs[i].lk, vecs[i].rec, vecs[i].wrap});
        end
        f_rst = 1'b0; f_ld = 1'b0; f_en = 1'b1;

        // Full period from the seed: wrap only on the 31st step
        for (int k = 2; k <= 30; k++) begin
            tick();
            chk($sformatf("fib_k%0d_wrap", k), 32'(f_wrap), 32'h0);
            chk($sformatf("fib_k%0d_cnt", k), 32'(f_cnt), 32'(k));
        end
        tick();
        chk("fib_period_q", 32'(f_q), 32'h01);
        chk("fib_period_wrap", 32'(f_wrap), 32'h1);
        chk("fib_period_cnt", 32'(f_cnt), 32'h0);
        tick();
        chk("fib_post_q", 32'(f_q), 32'h02);
        chk("fib_post_wrap", 32'(f_wrap), 32'h0);
        chk("fib_post_cnt", 32'(f_cnt), 32'h1);
        f_en = 1'b0;

        // Galois 8-bit: shift to 80 then reduce by 1D; period 255
        g_en = 1'b1;
        for (int k = 1; k <= 254; k++) begin
            tick();
            chk($sformatf("gal_k%0d_wrap", k), 32'(g_wrap), 32'h0);
            if (k == 7) chk("gal_k7_q", 32'(g_q), 32'h80);
            if (k == 8) begin
                chk("gal_k8_q", 32'(g_q), 32'h1D);
                chk("gal_k8_cnt", 32'(g_cnt), 32'd8);
            end
        end
        tick();
        chk("gal_period_q", 32'(g_q), 32'h01);
        chk("gal_period_wrap", 32'(g_wrap), 32'h1);
        chk("gal_period_cnt", 32'(g_cnt), 32'h0);
        g_en = 1'b0;
        tick();
        chk("gal_hold_q", 32'(g_q), 32'h01);
        chk("gal_hold_wrap", 32'(g_wrap), 32'h0);

        // XNOR: all-ones is the lock state, recovery falls back to SEED
        x_ld = 1'b1; x_seed = 5'h1F;
        tick();
        chk("xnr_load_q", 32'(x_q), 32'h1F);
        chk("xnr_load_lk", 32'(x_lk), 32'h1);
        x_ld = 1'b0; x_en = 1'b1;
        tick();
        chk("xnr_rec_q", 32'(x_q), 32'h01);
        chk("xnr_rec_flags", {29'd0, x_lk, x_rec, x_wrap}, 32'h2);
        chk("xnr_rec_cnt", 32'(x_cnt), 32'h0);
        tick();
        chk("xnr_step1_q", 32'(x_q), 32'h03);
        chk("xnr_step1_flags", {29'd0, x_lk, x_rec, x_wrap}, 32'h0);
        chk("xnr_step1_cnt", 32'(x_cnt), 32'h1);
        tick();
        chk("xnr_step2_q", 32'(x_q), 32'h07);
        x_en = 1'b0;
        tick();
        chk("xnr_hold_q", 32'(x_q), 32'h07);
        chk("xnr_hold_cnt", 32'(x_cnt), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
